// File: rtl/rdma_sched_pkg.sv
// Shared types and constants for the read-DMA row scheduler and its helpers.
package rdma_sched_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_CHECK = S_CHECK,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_GAP   = S_GAP,
    ST_DONE  = S_DONE
  } sched_state_t;

  localparam logic [31:0] MIN_ROW_BYTES   = 32'd64;
  localparam int          RDMA_BEAT_SHIFT = 3;

  // Index of the final beat of a row, counting from zero.
  function automatic logic [31:0] row_last_beat(input logic [31:0] row_bytes);
    return (row_bytes >> RDMA_BEAT_SHIFT) - 32'd1;
  endfunction

endpackage

// File: rtl/rdma_beat_cnt.sv
// Data-beat counter: counts strobes up to a terminal index and flags the last one.
module rdma_beat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         last
);

  logic [W-1:0] cnt_r;

  // The strobe is qualified by en so it fires on the terminal beat only.
  assign last = en && (cnt_r == term);

  // Beat counter, wraps to zero on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (last) cnt_r <= '0;
      else      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rdma_row_sched.sv
// Row sequencer for the 64-bit read-DMA engine: one DMA transfer per feature-map row.
// Optional WAIT-cycle performance counter enabled by defining RDMA_SCHED_PERF_EN.
module rdma_row_sched
  import rdma_sched_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int ROW_CNT_W  = 16,
  parameter int GAP_CYC    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_base_addr,
  input  logic [31:0]          cfg_row_stride,
  input  logic [31:0]          cfg_row_bytes,
  input  logic [ROW_CNT_W-1:0] cfg_row_cnt,
  input  logic                 cfg_abort,
  output logic                 rdma_start,
  output logic [31:0]          rdma_base_addr,
  output logic [31:0]          rdma_transfer_byte,
  input  logic                 rdma_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err,
  output logic [ROW_CNT_W-1:0] rows_done,
  output logic [31:0]          perf_wait_cyc
);

  sched_state_t         state_r, state_nx_s;
  logic [31:0]          base_r, stride_r, row_bytes_r, term_r;
  logic [ROW_CNT_W-1:0] row_cnt_r, rows_done_r;
  logic [31:0]          row_addr_r, row_addr_nx_s;
  logic [31:0]          rdma_base_addr_r, rdma_transfer_byte_r;
  logic [7:0]           gap_cnt_r;
  logic                 rdma_start_r, busy_r, done_r, aborted_r, err_r;
  logic                 abort_r, fin_done_r;
  logic                 start_acc_s, cfg_bad_s, beat_en_s, last_beat_s, fin_beat_s;
  logic                 gap_end_s, more_rows_s, stray_s;

  assign start_acc_s = (state_r == ST_IDLE) && cfg_start;
  assign cfg_bad_s   = (row_cnt_r == '0) || (row_bytes_r < MIN_ROW_BYTES) ||
                       ((row_bytes_r & 32'(BEAT_BYTES - 1)) != 32'd0);
  assign beat_en_s   = (state_r == ST_WAIT) && rdma_valid;
  assign stray_s     = rdma_valid && (state_r != ST_WAIT);
  assign fin_beat_s  = last_beat_s && ((rows_done_r + ROW_CNT_W'(1)) == row_cnt_r);
  assign gap_end_s   = (state_r == ST_GAP) && ((int'(gap_cnt_r) + 1) >= GAP_CYC);
  assign more_rows_s = (rows_done_r != row_cnt_r) && !abort_r;

  rdma_beat_cnt #(.W(32)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_r == ST_CHECK),
    .en    (beat_en_s),
    .term  (term_r),
    .last  (last_beat_s)
  );

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (cfg_start) state_nx_s = ST_CHECK; else state_nx_s = ST_IDLE;
      ST_CHECK: if (cfg_bad_s) state_nx_s = ST_DONE;  else state_nx_s = ST_ISSUE;
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT:  if (last_beat_s) state_nx_s = ST_GAP; else state_nx_s = ST_WAIT;
      ST_GAP: begin
        if (gap_end_s) begin
          if (more_rows_s) state_nx_s = ST_ISSUE;
          else             state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Row address: base on validation, advanced by the stride before each later row.
  always_comb begin
    row_addr_nx_s = row_addr_r;
    if (state_r == ST_CHECK) begin
      row_addr_nx_s = base_r;
    end else if ((state_r == ST_GAP) && (state_nx_s == ST_ISSUE)) begin
      row_addr_nx_s = row_addr_r + stride_r;
    end else begin
      row_addr_nx_s = row_addr_r;
    end
  end

  // State, configuration latch and engine-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r              <= ST_IDLE;
      base_r               <= 32'd0;
      stride_r             <= 32'd0;
      row_bytes_r          <= 32'd0;
      row_cnt_r            <= '0;
      term_r               <= 32'd0;
      row_addr_r           <= 32'd0;
      rdma_start_r         <= 1'b0;
      rdma_base_addr_r     <= 32'd0;
      rdma_transfer_byte_r <= 32'd0;
      busy_r               <= 1'b0;
      done_r               <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      row_addr_r   <= row_addr_nx_s;
      rdma_start_r <= (state_nx_s == ST_ISSUE);
      done_r       <= (state_nx_s == ST_DONE);
      busy_r       <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
      if (start_acc_s) begin
        base_r      <= cfg_base_addr;
        stride_r    <= cfg_row_stride;
        row_bytes_r <= cfg_row_bytes;
        row_cnt_r   <= cfg_row_cnt;
      end
      if (state_r == ST_CHECK) term_r <= row_last_beat(row_bytes_r);
      // Held from ISSUE through the row's last beat; the engine samples late.
      if (state_nx_s == ST_ISSUE) begin
        rdma_base_addr_r     <= row_addr_nx_s;
        rdma_transfer_byte_r <= row_bytes_r;
      end
    end
  end

  // Gap timer between a row's last beat and the next decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 gap_cnt_r <= 8'd0;
    else if (state_r == ST_GAP) gap_cnt_r <= gap_cnt_r + 8'd1;
    else                        gap_cnt_r <= 8'd0;
  end

  // Status: sticky error, row count, abort latch and abort qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r       <= 1'b0;
      rows_done_r <= '0;
      abort_r     <= 1'b0;
      fin_done_r  <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      if (stray_s || ((state_r == ST_CHECK) && cfg_bad_s)) err_r <= 1'b1;
      else if (start_acc_s)                                 err_r <= 1'b0;

      if (start_acc_s)      rows_done_r <= '0;
      else if (last_beat_s) rows_done_r <= rows_done_r + ROW_CNT_W'(1);

      if (start_acc_s)     fin_done_r <= 1'b0;
      else if (fin_beat_s) fin_done_r <= 1'b1;

      // An abort arriving with, or after, the final row's last beat is too late to count.
      if (start_acc_s) begin
        abort_r <= 1'b0;
      end else if ((state_r != ST_IDLE) && cfg_abort && !fin_done_r && !fin_beat_s) begin
        abort_r <= 1'b1;
      end

      if (start_acc_s)                 aborted_r <= 1'b0;
      else if (state_nx_s == ST_DONE)  aborted_r <= abort_r;
    end
  end

`ifdef RDMA_SCHED_PERF_EN
  logic [31:0] perf_r;

  // Saturating count of cycles spent waiting on data beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  perf_r <= 32'd0;
    else if (start_acc_s)                                        perf_r <= 32'd0;
    else if ((state_r == ST_WAIT) && (perf_r != 32'hFFFF_FFFF))  perf_r <= perf_r + 32'd1;
    else                                                         perf_r <= perf_r;
  end

  assign perf_wait_cyc = perf_r;
`else
  assign perf_wait_cyc = 32'd0;
`endif

  assign rdma_start         = rdma_start_r;
  assign rdma_base_addr     = rdma_base_addr_r;
  assign rdma_transfer_byte = rdma_transfer_byte_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign aborted            = aborted_r;
  assign err                = err_r;
  assign rows_done          = rows_done_r;

endmodule

// File: doc/rdma_row_sched.md
# rdma_row_sched

Row-sequencing controller for the 64-bit read-DMA engine feeding the YOLOv2 accelerator's input BRAM. A layer descriptor (base, stride, row size, row count) is expanded into one DMA transfer per feature-map row. The block drives the engine's `start`, `base_addr` and `transfer_byte` inputs, and counts returned data beats to detect row completion. It sits between the layer control registers and the read-DMA instance.

## Interface
- `BEAT_BYTES`, 8: bytes per AXI data beat; the engine is 64-bit.
- `ROW_CNT_W`, 16: width of the row counter.
- `GAP_CYC`, 2: idle cycles between the last beat of a row and the next start.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: one-cycle request; sampled only in IDLE.
- `cfg_base_addr` in 32: byte address of row 0.
- `cfg_row_stride` in 32: byte distance between consecutive row starts.
- `cfg_row_bytes` in 32: bytes per row.
- `cfg_row_cnt` in ROW_CNT_W: number of rows.
- `cfg_abort` in 1: stop after the current row completes.
- `rdma_start` out 1: start level to the DMA engine; the engine detects the rising edge.
- `rdma_base_addr` out 32: current row address.
- `rdma_transfer_byte` out 32: current row byte count.
- `rdma_valid` in 1: data-beat strobe from the DMA engine (R handshake).
- `busy` out 1: high from the accepted `cfg_start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: qualifies `done`; held until the next `cfg_start`.
- `err` out 1: sticky error flag; cleared on `cfg_start`.
- `rows_done` out ROW_CNT_W: count of completed rows.
- `perf_wait_cyc` out 32: performance counter (see Configuration).

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, GAP, DONE.
- IDLE:
  - On `cfg_start`, latch all `cfg_*` inputs.
  - Clear `err`, `aborted`, `rows_done` and the abort latch.
  - Go to CHECK.
- CHECK: the configuration is invalid if any of the following holds:
  - `row_cnt==0`
  - `row_bytes<64`, because the engine's first burst is a fixed 8 beats
  - `row_bytes[2:0]!=0`
  - On invalid: set `err`, go to DONE.
  - On valid: set `row_addr=base`, `row_beats=row_bytes>>3`, `beat_cnt=0`, go to ISSUE.
- ISSUE: `rdma_start=1` for exactly one cycle, then WAIT.
- WAIT:
  - `beat_cnt` increments on each `rdma_valid`.
  - When `rdma_valid && beat_cnt==row_beats-1`: increment `rows_done`, clear `beat_cnt`, go to GAP.
- GAP:
  - Hold for GAP_CYC cycles.
  - If `rows_done==row_cnt` or the abort latch is set, go to DONE.
  - Otherwise set `row_addr += row_stride`, go to ISSUE.
- DONE: `done=1` for one cycle, then IDLE.
- Abort:
  - `cfg_abort` in any non-IDLE state sets the abort latch.
  - An in-flight row is never truncated, because the engine has no cancel.
  - `aborted=1` at DONE if the latch was set before the final row completed.
- Error on stray beats: `rdma_valid` outside WAIT sets `err` and the beat is ignored.
- Arithmetic:
  - `row_addr` is 32-bit modulo; wrap is permitted and is not an error.
  - `rows_done` compares at full ROW_CNT_W width.
- `rdma_base_addr` and `rdma_transfer_byte` are stable from ISSUE until the row's last beat; the engine samples them one cycle after its start edge.
- `cfg_start` outside IDLE is ignored.
- Simultaneous abort and last beat of the final row: `aborted=0`.

## Timing
- All outputs are registered. Reset values:
  - `rdma_start` = 0
  - `busy` = 0
  - `done` = 0
  - `aborted` = 0
  - `err` = 0
  - `rows_done` = 0
  - `rdma_base_addr` = 0
  - `rdma_transfer_byte` = 0
  - `perf_wait_cyc` = 0
- Latency from `cfg_start` to the first `rdma_start`: 2 cycles (CHECK, then ISSUE).
- `rdma_start` is low for at least GAP_CYC+1 cycles between pulses, which guarantees a fresh rising edge.
- Latency from the final row's last beat to `done`: GAP_CYC+1 cycles.
- Invalid configuration: `done` and `err` are asserted 2 cycles after `cfg_start`; `rdma_start` is never asserted.
- Reset asserted mid-transfer: all state returns to IDLE immediately. The DMA engine shares `rst_n`, so no transfer survives the reset.

## Configuration
- `RDMA_SCHED_PERF_EN` defined:
  - `perf_wait_cyc` counts cycles spent in WAIT.
  - The counter clears on the accepted `cfg_start` and saturates at 0xFFFFFFFF.
- `RDMA_SCHED_PERF_EN` undefined: the port exists but is tied to 0, and no counter logic is built.

## Structure
- Shared package `rdma_sched_pkg`:
  - state enum `sched_state_t`
  - `MIN_ROW_BYTES=64`
  - beat-size constant `RDMA_BEAT_SHIFT=3`
- Sub-module `rdma_beat_cnt`: counts beats against a terminal value and emits a last-beat strobe. It is reusable by the other read-DMA channels.

## Test plan
- Three-row read: base 0x1000_0000, stride 0x400, row_bytes 256, rows 3, one beat per cycle.
  - Expect 3 `rdma_start` pulses with addresses 0x1000_0000, 0x1000_0400, 0x1000_0800, each with transfer_byte 256.
  - Expect `done` after 96 beats, `rows_done=3`, `err=0`.
- Invalid row size: row_bytes 60.
  - Expect `err=1` and `done` 2 cycles after `cfg_start`; no `rdma_start` pulse.
- Abort mid-layer: assert `cfg_abort` during beat 10 of row 1 of 4.
  - Expect row 1 to finish all 32 beats and no third start.
  - Expect `done` with `aborted=1` and `rows_done=2`.
- Stray beat: `rdma_valid` pulsed in IDLE.
  - Expect `err=1` sticky; the next `cfg_start` clears it.
- Reset mid-transfer: drop `rst_n` during WAIT.
  - Expect all outputs 0 immediately.
  - Expect a following valid run to complete normally.
- Performance counter, `RDMA_SCHED_PERF_EN` defined: one 32-beat row with `rdma_valid` on alternate cycles.
  - Expect `perf_wait_cyc` in the range 63..64.
  - With the macro undefined, expect 0.
